// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
// Program-ROM fetch bus between the CPU sequencer and the program ROM.
//   rom_req  : fetch request, high for the whole fetch (master -> slave)
//   rom_addr : fetch address, PC_W bits              (master -> slave)
//   rom_ack  : instruction valid this cycle          (slave  -> master)
//   rom_data : 8-bit instruction, [7:4] op, [3:0] imm (slave -> master)
// Modports: master = sequencer side, slave = ROM side.
// ---------------------------------------------------------------------------
interface cpu_sequencer_if #(
   parameter int PC_W = 4
);
   logic            rom_req;
   logic [PC_W-1:0] rom_addr;
   logic            rom_ack;
   logic [7:0]      rom_data;

   modport master (
      output rom_req,
      output rom_addr,
      input  rom_ack,
      input  rom_data
   );

   modport slave (
      input  rom_req,
      input  rom_addr,
      output rom_ack,
      output rom_data
   );
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Fetch/execute sequencer for the 4-bit CPU. Owns the program counter and the
// instruction register, fetches instructions over the ROM bus, and opens a
// single execute cycle per instruction. Free-run and single-step modes; a
// taken jump whose target is the current pc halts the block until reset.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   run, step   : free-run level / single-instruction pulse (sampled in IDLE)
//   rom         : ROM fetch bus (master side)
//   op_out      : IR[7:4] to the decoder
//   imm_out     : IR[3:0] to the ALU immediate operand
//   pc_load_in  : decoder "take jump", sampled in EXEC only
//   exec_en     : execute window, gates every datapath load strobe
//   pc          : program counter
//   halted      : high once a jump-to-self has executed
//   retired     : executed-instruction count, wraps at 8 bits
// ---------------------------------------------------------------------------
module cpu_sequencer #(
   parameter int PC_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  step,
   cpu_sequencer_if.master       rom,
   output logic [3:0]            op_out,
   output logic [3:0]            imm_out,
   input  logic                  pc_load_in,
   output logic                  exec_en,
   output logic [PC_W-1:0]       pc,
   output logic                  halted,
   output logic [7:0]            retired
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t          state_q,   state_d;
   logic [PC_W-1:0] pc_q,      pc_d;
   logic [7:0]      ir_q,      ir_d;
   logic [7:0]      retired_q, retired_d;
   logic            rom_req_q, rom_req_d;
   logic            exec_en_q, exec_en_d;
   logic            halted_q,  halted_d;

   logic [PC_W-1:0] imm_ext;

   // Jump target is the immediate, zero-extended to the pc width.
   assign imm_ext = PC_W'(ir_q[3:0]);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; a missing default here would infer a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;

      case (state_q)
         S_IDLE: begin
            if (run || step) state_d = S_FETCH;
         end
         S_FETCH: begin
            // IR is only ever written here, on an accepted fetch.
            if (rom.rom_ack) begin
               ir_d    = rom.rom_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            retired_d = retired_q + 8'd1;
            if (pc_load_in && (imm_ext == pc_q)) begin
               state_d = S_HALT;
            end else begin
               pc_d    = pc_load_in ? imm_ext : pc_q + PC_W'(1);
               state_d = run ? S_FETCH : S_IDLE;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobes are decoded from the next state and registered, so they are
      // pure functions of the state register with no input-to-output path.
      rom_req_d = (state_d == S_FETCH);
      exec_en_d = (state_d == S_EXEC);
      halted_d  = (state_d == S_HALT);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before this edge regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= 8'h00;
         retired_q <= 8'h00;
         rom_req_q <= 1'b0;
         exec_en_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
         rom_req_q <= rom_req_d;
         exec_en_q <= exec_en_d;
         halted_q  <= halted_d;
      end
   end

   assign rom.rom_req  = rom_req_q;
   assign rom.rom_addr = pc_q;
   assign pc           = pc_q;
   assign op_out       = ir_q[7:4];
   assign imm_out      = ir_q[3:0];
   assign exec_en      = exec_en_q;
   assign halted       = halted_q;
   assign retired      = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Self-checking bench for cpu_sequencer: a per-cycle vector table, a few
// hand-written multi-cycle sequences, and random programs checked against an
// instruction-level reference model with a wait-state ROM responder.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

   localparam int PC_W = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            run;
   logic            step;
   logic [3:0]      op_out;
   logic [3:0]      imm_out;
   logic            pc_load_in;
   logic            exec_en;
   logic [PC_W-1:0] pc;
   logic            halted;
   logic [7:0]      retired;

   // Stimulus controls: manual drive or automatic ROM/decoder behaviour.
   logic            rom_auto;
   logic            dec_auto;
   logic            rom_ack_drv;
   logic [7:0]      rom_data_drv;
   logic            pc_load_drv;
   logic [7:0]      rom_mem [16];

   int checks = 0;
   int errors = 0;

   cpu_sequencer_if #(.PC_W(PC_W)) rom_bus ();

   assign rom_bus.rom_ack  = rom_ack_drv;
   assign rom_bus.rom_data = rom_auto ? rom_mem[rom_bus.rom_addr] : rom_data_drv;
   // Minimal decoder: opcode F is an unconditional jump.
   assign pc_load_in       = dec_auto ? (op_out == 4'hF) : pc_load_drv;

   cpu_sequencer #(.PC_W(PC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .step       (step),
      .rom        (rom_bus.master),
      .op_out     (op_out),
      .imm_out    (imm_out),
      .pc_load_in (pc_load_in),
      .exec_en    (exec_en),
      .pc         (pc),
      .halted     (halted),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and land just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst, run, step, ack;
      logic [7:0] data;
      logic       pcl;
      logic       req, ex, hlt;
      logic [7:0] ir;
      logic [3:0] pcv;
      logic [7:0] ret;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rn, input logic st, input logic ak,
                               input logic [7:0] d, input logic pl, input logic rq,
                               input logic ex, input logic h, input logic [7:0] ir,
                               input logic [3:0] p, input logic [7:0] rt);
      vec_t v;
      v.rst = r; v.run = rn; v.step = st; v.ack = ak; v.data = d; v.pcl = pl;
      v.req = rq; v.ex = ex; v.hlt = h; v.ir = ir; v.pcv = p; v.ret = rt;
      return v;
   endfunction

   vec_t vt [27];

   // ---------------- random programs vs instruction-level model ----------------
   task automatic run_program(input int n_instr, input bit allow_jump);
      logic [3:0] m_pc;
      logic [7:0] m_ret;
      logic [7:0] word;
      bit         m_halt;
      int         instr, cyc, last_exec, cur_k, wcnt, limit;

      for (int i = 0; i < 16; i++) begin
         word = 8'($urandom_range(0, 255));
         if (!allow_jump && word[7:4] == 4'hF) word[7:4] = 4'hE;
         if (allow_jump && $urandom_range(0, 7) == 0) word = {4'hF, 4'(i)};
         rom_mem[i] = word;
      end

      rom_auto = 1'b1; dec_auto = 1'b1;
      rst = 1'b1; run = 1'b0; step = 1'b0; rom_ack_drv = 1'b0;
      tick();
      rst = 1'b0; run = 1'b1;

      m_pc = '0; m_ret = '0; m_halt = 1'b0;
      instr = 0; cyc = 0; last_exec = -1; wcnt = 0;
      cur_k = $urandom_range(0, 3);
      limit = n_instr * 6 + 20;

      while (instr < n_instr && !m_halt && cyc < limit) begin
         if (rom_bus.rom_req) begin
            rom_ack_drv = (wcnt == cur_k);
            wcnt++;
         end else begin
            rom_ack_drv = 1'($urandom_range(0, 1));   // stray acks must be ignored
            wcnt = 0;
         end
         step = 1'($urandom_range(0, 1));
         tick();
         cyc++;
         if (exec_en) begin
            word = rom_mem[m_pc];
            check("rnd_pc", pc, m_pc);
            check("rnd_op", op_out, word[7:4]);
            check("rnd_imm", imm_out, word[3:0]);
            check("rnd_retired", retired, m_ret);
            if (last_exec >= 0) check("rnd_cycles_per_instr", cyc - last_exec, cur_k + 2);
            last_exec = cyc;
            cur_k = $urandom_range(0, 3);
            if (word[7:4] == 4'hF && word[3:0] == m_pc) m_halt = 1'b1;
            else if (word[7:4] == 4'hF)                  m_pc = word[3:0];
            else                                          m_pc = m_pc + 4'd1;
            m_ret = m_ret + 8'd1;
            instr++;
         end
      end

      if (!m_halt && instr < n_instr) check("rnd_timeout", 0, 1);

      if (m_halt) begin
         for (int c = 0; c < 4; c++) begin
            rom_ack_drv = 1'b1;
            step = 1'($urandom_range(0, 1));
            tick();
            check("rnd_halted", halted, 1'b1);
            check("rnd_halt_pc", pc, m_pc);
            check("rnd_halt_req", rom_bus.rom_req, 1'b0);
            check("rnd_halt_retired", retired, m_ret);
         end
      end
      run = 1'b0; step = 1'b0; rom_ack_drv = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; step = 1'b0;
      rom_auto = 1'b0; dec_auto = 1'b0;
      rom_ack_drv = 1'b0; rom_data_drv = 8'h00; pc_load_drv = 1'b0;
      for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;

      //            rst run stp ack data   pcl  req ex hlt  ir     pc    ret
      vt[0]  = mk(1, 0, 0, 0, 8'h00, 0,   0, 0, 0, 8'h00, 4'd0, 8'd0);
      vt[1]  = mk(0, 1, 0, 0, 8'h00, 0,   0, 0, 0, 8'h00, 4'd0, 8'd0);
      vt[2]  = mk(0, 1, 0, 1, 8'h33, 0,   1, 0, 0, 8'h00, 4'd0, 8'd0);
      vt[3]  = mk(0, 1, 0, 0, 8'h00, 0,   0, 1, 0, 8'h33, 4'd0, 8'd0);
      vt[4]  = mk(0, 1, 0, 1, 8'h15, 0,   1, 0, 0, 8'h33, 4'd1, 8'd1);
      vt[5]  = mk(0, 1, 0, 0, 8'h00, 0,   0, 1, 0, 8'h15, 4'd1, 8'd1);
      vt[6]  = mk(0, 0, 0, 1, 8'h00, 0,   1, 0, 0, 8'h15, 4'd2, 8'd2);  // run falls in FETCH
      vt[7]  = mk(0, 0, 0, 0, 8'h00, 0,   0, 1, 0, 8'h00, 4'd2, 8'd2);
      vt[8]  = mk(0, 0, 0, 1, 8'hAA, 0,   0, 0, 0, 8'h00, 4'd3, 8'd3);  // ack in IDLE
      vt[9]  = mk(0, 0, 0, 1, 8'hAA, 1,   0, 0, 0, 8'h00, 4'd3, 8'd3);
      vt[10] = mk(0, 0, 1, 0, 8'h00, 0,   0, 0, 0, 8'h00, 4'd3, 8'd3);  // step
      vt[11] = mk(0, 0, 0, 0, 8'h2C, 0,   1, 0, 0, 8'h00, 4'd3, 8'd3);  // wait 1
      vt[12] = mk(0, 0, 1, 0, 8'h2C, 0,   1, 0, 0, 8'h00, 4'd3, 8'd3);  // wait 2, step ignored
      vt[13] = mk(0, 0, 0, 0, 8'h2C, 0,   1, 0, 0, 8'h00, 4'd3, 8'd3);  // wait 3
      vt[14] = mk(0, 0, 0, 1, 8'h29, 0,   1, 0, 0, 8'h00, 4'd3, 8'd3);  // ack
      vt[15] = mk(0, 0, 0, 0, 8'h00, 1,   0, 1, 0, 8'h29, 4'd3, 8'd3);  // jump to 9
      vt[16] = mk(0, 0, 0, 1, 8'h00, 1,   0, 0, 0, 8'h29, 4'd9, 8'd4);
      vt[17] = mk(0, 0, 1, 0, 8'h00, 0,   0, 0, 0, 8'h29, 4'd9, 8'd4);
      vt[18] = mk(0, 0, 0, 1, 8'hF9, 0,   1, 0, 0, 8'h29, 4'd9, 8'd4);
      vt[19] = mk(0, 1, 0, 0, 8'h00, 1,   0, 1, 0, 8'hF9, 4'd9, 8'd4);  // jump-to-self
      vt[20] = mk(0, 1, 1, 1, 8'h00, 1,   0, 0, 1, 8'hF9, 4'd9, 8'd5);
      vt[21] = mk(0, 1, 0, 1, 8'h00, 0,   0, 0, 1, 8'hF9, 4'd9, 8'd5);
      vt[22] = mk(1, 1, 0, 0, 8'h00, 0,   0, 0, 0, 8'h00, 4'd0, 8'd0);  // async reset in HALT
      vt[23] = mk(0, 1, 0, 0, 8'h00, 0,   0, 0, 0, 8'h00, 4'd0, 8'd0);
      vt[24] = mk(0, 1, 0, 0, 8'h00, 0,   1, 0, 0, 8'h00, 4'd0, 8'd0);
      vt[25] = mk(1, 1, 0, 1, 8'h12, 0,   0, 0, 0, 8'h00, 4'd0, 8'd0);  // reset mid-FETCH
      vt[26] = mk(0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 8'h00, 4'd0, 8'd0);

      // Inputs are applied just after an edge; outputs are compared 1 time
      // unit later, still well before the next edge.
      for (int i = 0; i < 27; i++) begin
         rst = vt[i].rst; run = vt[i].run; step = vt[i].step;
         rom_ack_drv = vt[i].ack; rom_data_drv = vt[i].data; pc_load_drv = vt[i].pcl;
         #1;
         check($sformatf("vec%0d_rom_req", i), rom_bus.rom_req, vt[i].req);
         check($sformatf("vec%0d_exec_en", i), exec_en, vt[i].ex);
         check($sformatf("vec%0d_halted", i), halted, vt[i].hlt);
         check($sformatf("vec%0d_op_out", i), op_out, vt[i].ir[7:4]);
         check($sformatf("vec%0d_imm_out", i), imm_out, vt[i].ir[3:0]);
         check($sformatf("vec%0d_pc", i), pc, vt[i].pcv);
         check($sformatf("vec%0d_rom_addr", i), rom_bus.rom_addr, vt[i].pcv);
         check($sformatf("vec%0d_retired", i), retired, vt[i].ret);
         tick();
      end

      // ---- pc wrap 15 -> 0 via single-step ----
      rst = 1'b1; #1; rst = 1'b0; run = 1'b0;
      tick();
      step = 1'b1; tick(); step = 1'b0;
      rom_ack_drv = 1'b1; rom_data_drv = 8'h5F; tick();
      rom_ack_drv = 1'b0; pc_load_drv = 1'b1; tick();
      pc_load_drv = 1'b0;
      check("wrap_jump_pc", pc, 4'd15);
      check("wrap_jump_retired", retired, 8'd1);
      check("wrap_jump_idle", rom_bus.rom_req, 1'b0);
      step = 1'b1; tick(); step = 1'b0;
      rom_ack_drv = 1'b1; rom_data_drv = 8'h70; tick();
      rom_ack_drv = 1'b0;
      check("wrap_exec_en", exec_en, 1'b1);
      tick();
      check("wrap_pc", pc, 4'd0);
      check("wrap_retired", retired, 8'd2);
      check("wrap_exec_done", exec_en, 1'b0);
      tick();
      check("wrap_no_extra_fetch", rom_bus.rom_req, 1'b0);

      // ---- reset mid-EXEC discards the instruction ----
      run = 1'b1; tick();
      rom_ack_drv = 1'b1; rom_data_drv = 8'h11; tick();
      rom_ack_drv = 1'b0;
      check("rstexec_in_exec", exec_en, 1'b1);
      rst = 1'b1; #1;
      check("rstexec_exec_en", exec_en, 1'b0);
      check("rstexec_retired", retired, 8'd0);
      check("rstexec_pc", pc, 4'd0);
      check("rstexec_op", op_out, 4'd0);
      run = 1'b0; rst = 1'b0;
      tick();

      // ---- random programs ----
      run_program(300, 1'b0);   // long straight-line run exercises retired wrap
      for (int p = 0; p < 6; p++) run_program(60, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute bound on run time.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
